// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a FIFO read port and sends each one as an
// asynchronous serial frame (start, DATA_WIDTH bits LSB first, optional
// parity, stop) on a single registered line.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | line high, waiting for enable && !empty
// FETCH    | one-cycle pop request to the FIFO
// LOAD     | capture popped word, compute parity, clear bit timer
// START    | start bit (low) for BIT_CYCLES cycles
// DATA     | data bits LSB first, BIT_CYCLES cycles each
// PARITY_S | parity bit for BIT_CYCLES cycles (only when PARITY != 0)
// STOP     | stop bit (high); last cycle counts the frame and decides next
module fifo_serial_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 16,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  Read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [15:0]      LAST_CYC = 16'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY_S, STOP
  } state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [15:0]           cyc_q, cyc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_q, par_d;
  logic [15:0]           fc_d;
  logic                  tx_d;
  logic                  bit_end;

  // Pop request and busy are pure decodes of the state register.
  assign Read_enable = (state == FETCH);
  assign busy        = (state != IDLE);

  // Next-state, datapath and next line level; tx is registered from the
  // next state so it changes exactly on the edge that enters each bit.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    par_d   = par_q;
    fc_d    = frame_count;
    bit_end = (cyc_q == LAST_CYC);
    case (state)
      IDLE: begin
        if (enable && !empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = data_out;
        par_d   = (PARITY == 2) ? ~^data_out : ^data_out;
        cyc_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? PARITY_S : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      PARITY_S: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          fc_d    = frame_count + 16'd1;
          state_d = (enable && !empty) ? FETCH : IDLE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:    tx_d = 1'b0;
      DATA:     tx_d = shift_d[0];
      PARITY_S: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shift_q     <= '0;
      cyc_q       <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      frame_count <= '0;
      tx          <= 1'b1;
    end else begin
      state       <= state_d;
      shift_q     <= shift_d;
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      frame_count <= fc_d;
      tx          <= tx_d;
    end
  end

endmodule
